switch_regfile_alu: RTL

- Parametrised successor to the switch-driven two-register XOR demo.
- Holds NREGS registers of WIDTH bits and executes one operation per `go` request through a 4-state FSM: load from switches, move, add, subtract, AND, OR, XOR, clear.
- Drives status flags and a seven-segment view of a selectable register, one digit per nibble.
- Sits between board switches/keys and the HEX displays on the DE2 lab top level.

---
 rtl/switch_regfile_alu.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/switch_regfile_alu.sv
// Switch-driven register file with a 4-state ALU sequencer and a seven-segment register view.
// Optional build macro SWITCH_ALU_ROTATE_EN turns op 111 from CLR into rotate-left.
module switch_regfile_alu #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         SW_data,
  input  logic [AW-1:0]            dst,
  input  logic [AW-1:0]            src,
  input  logic [2:0]               op,
  input  logic                     go,
  input  logic [AW-1:0]            disp_sel,
  output logic                     ready,
  output logic                     done,
  output logic [3:0]               flags,
  output logic [7*(WIDTH/4)-1:0]   HEX
);

  localparam int NDIG = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [2:0]       opLat;
  logic [AW-1:0]    dstLat;
  logic [AW-1:0]    srcLat;
  logic [WIDTH-1:0] dataLat;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] resHold;
  logic [3:0]       flagHold;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;
  logic [WIDTH-1:0] dispVal;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // SUB reports borrow-not in C, so C=1 whenever A>=B unsigned
  always_comb begin
    sum    = {1'b0, opA} + {1'b0, opB};
    diff   = opA - opB;
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (opLat)
      3'b000: aluRes = dataLat;
      3'b001: aluRes = opB;
      3'b010: begin
        aluRes = sum[WIDTH-1:0];
        aluC   = sum[WIDTH];
        aluV   = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
      end
      3'b011: begin
        aluRes = diff;
        aluC   = (opA >= opB);
        aluV   = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
      end
      3'b100: aluRes = opA & opB;
      3'b101: aluRes = opA | opB;
      3'b110: aluRes = opA ^ opB;
      3'b111: begin
`ifdef SWITCH_ALU_ROTATE_EN
        aluRes = {opA[WIDTH-2:0], opA[WIDTH-1]};
        aluC   = opA[WIDTH-1];
`else
        aluRes = '0;
`endif
      end
    endcase
  end

  always_comb begin
    dispVal = regs[disp_sel];
    HEX     = '0;
    for (int k = 0; k < NDIG; k++) begin
      HEX[7*k +: 7] = seg7(dispVal[4*k +: 4]);
    end
  end

  // Operands are captured in READ, so dst==src sees the pre-write value
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      flags    <= '0;
      opLat    <= '0;
      dstLat   <= '0;
      srcLat   <= '0;
      dataLat  <= '0;
      opA      <= '0;
      opB      <= '0;
      resHold  <= '0;
      flagHold <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            opLat   <= op;
            dstLat  <= dst;
            srcLat  <= src;
            dataLat <= SW_data;
            ready   <= 1'b0;
            state   <= READ;
          end
        end
        READ: begin
          opA   <= regs[dstLat];
          opB   <= regs[srcLat];
          state <= EXEC;
        end
        EXEC: begin
          resHold  <= aluRes;
          flagHold <= {aluRes[WIDTH-1], (aluRes == '0), aluC, aluV};
          state    <= WRITE;
        end
        WRITE: begin
          regs[dstLat] <= resHold;
          flags        <= flagHold;
          done         <= 1'b1;
          ready        <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
